// File: rtl/reset_sequencer.sv
// Sequenced reset release: domains come out of reset one at a time in index order,
// each after a programmable delay and a ready handshake bounded by a timeout.
module reset_sequencer #(
  parameter int NUM_DOMAINS   = 4,
  parameter int RELEASE_DELAY = 16,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   soft_rst_req,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] domain_rst_n_out,
  output logic                   all_released,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [((NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1)-1:0] cur_domain
);

  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int CNT_MAX = (RELEASE_DELAY > ACK_TIMEOUT) ? RELEASE_DELAY : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_DELAY      = 2'd0,
    S_WAIT_READY = 2'd1,
    S_RUN        = 2'd2,
    S_ASSERT_ALL = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   all_rel_q, all_rel_d;
  logic                   busy_q, busy_d;
  logic                   terr_q, terr_d;

  logic soft_abort;
  logic dly_done;
  logic ack_seen;
  logic ack_tmo;
  logic last_dom;
  logic advance;

  // A request already being served in ASSERT_ALL only extends the hold.
  assign soft_abort = soft_rst_req && (state_q != S_ASSERT_ALL);
  assign dly_done   = (cnt_q == DLY_LAST);
  assign ack_seen   = domain_ready[idx_q];
  assign ack_tmo    = (cnt_q == TMO_LAST);
  assign last_dom   = (idx_q == IDX_LAST);
  assign advance    = (state_q == S_WAIT_READY) && (ack_seen || ack_tmo);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_DELAY;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_n_q   <= '0;
      all_rel_q <= 1'b0;
      busy_q    <= 1'b1;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_n_q   <= rst_n_d;
      all_rel_q <= all_rel_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (soft_abort) begin
      state_d = S_ASSERT_ALL;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_DELAY: begin
          if (dly_done) begin
            cnt_d   = '0;
            state_d = S_WAIT_READY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_READY: begin
          if (advance) begin
            cnt_d = '0;
            if (last_dom) begin
              state_d = S_RUN;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_DELAY;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ASSERT_ALL: begin
          // Counter parks at its terminal value while the request stays high.
          if (dly_done) begin
            if (!soft_rst_req) begin
              cnt_d   = '0;
              state_d = S_DELAY;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    rst_n_d   = rst_n_q;
    all_rel_d = all_rel_q;
    terr_d    = terr_q;
    if (soft_abort) begin
      rst_n_d   = '0;
      all_rel_d = 1'b0;
      terr_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_DELAY: begin
          if (dly_done) begin
            rst_n_d[idx_q] = 1'b1;
          end
        end
        S_WAIT_READY: begin
          if (advance) begin
            if (!ack_seen) begin
              terr_d = 1'b1;
            end
            if (last_dom) begin
              all_rel_d = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
    busy_d = (state_d != S_RUN);
  end

  assign domain_rst_n_out = rst_n_q;
  assign all_released     = all_rel_q;
  assign busy             = busy_q;
  assign timeout_err      = terr_q;
  assign cur_domain       = idx_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: event-time reference model compared every cycle,
// directed scenarios with literal edge expectations, then randomized traffic.
module tb_reset_sequencer;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int AT = 8;

  localparam int PH_DLY  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_HOLD = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          soft_rst_req = 1'b0;
  logic [ND-1:0] domain_ready = '1;
  logic [ND-1:0] domain_rst_n_out;
  logic          all_released;
  logic          busy;
  logic          timeout_err;
  logic [1:0]    cur_domain;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_DOMAINS  (ND),
    .RELEASE_DELAY(RD),
    .ACK_TIMEOUT  (AT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .soft_rst_req    (soft_rst_req),
    .domain_ready    (domain_ready),
    .domain_rst_n_out(domain_rst_n_out),
    .all_released    (all_released),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .cur_domain      (cur_domain)
  );

  always #5 clk = ~clk;

  // Reference: absolute edge numbers at which the next event is due.
  typedef struct packed {
    int          n;
    int          idx;
    int          phase;
    int          t_evt;
    logic [ND-1:0] rel;
    logic        all_r;
    logic        terr;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.n     = 0;
    r.idx   = 0;
    r.phase = PH_DLY;
    r.t_evt = RD;
    r.rel   = '0;
    r.all_r = 1'b0;
    r.terr  = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, logic req, logic [ND-1:0] rdy);
    mdl_t r;
    r   = s;
    r.n = s.n + 1;
    if (req && s.phase != PH_HOLD) begin
      r.rel   = '0;
      r.all_r = 1'b0;
      r.terr  = 1'b0;
      r.idx   = 0;
      r.phase = PH_HOLD;
      r.t_evt = r.n + RD;
    end else begin
      case (s.phase)
        PH_DLY: begin
          if (r.n == s.t_evt) begin
            r.rel[s.idx] = 1'b1;
            r.phase      = PH_WAIT;
            r.t_evt      = r.n + AT;
          end
        end
        PH_WAIT: begin
          if (rdy[s.idx] || r.n == s.t_evt) begin
            if (!rdy[s.idx]) r.terr = 1'b1;
            if (s.idx == ND - 1) begin
              r.phase = PH_RUN;
              r.all_r = 1'b1;
            end else begin
              r.idx   = s.idx + 1;
              r.phase = PH_DLY;
              r.t_evt = r.n + RD;
            end
          end
        end
        PH_HOLD: begin
          if (r.n >= s.t_evt && !req) begin
            r.phase = PH_DLY;
            r.t_evt = r.n + RD;
          end
        end
        default: begin
        end
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= mdl_reset();
    else          m <= mdl_step(m, soft_rst_req, domain_ready);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, m.n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("domain_rst_n_out", 32'(domain_rst_n_out), 32'(m.rel));
    chk("all_released", 32'(all_released), 32'(m.all_r));
    chk("busy", 32'(busy), 32'(m.phase != PH_RUN));
    chk("timeout_err", 32'(timeout_err), 32'(m.terr));
    chk("cur_domain", 32'(cur_domain), 32'(m.idx));
  end

  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    while (m.n < k && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (m.n != k) begin
      errors++;
      $display("FAIL wait_edge: reached edge %0d, required %0d", m.n, k);
    end
  endtask

  task automatic do_reset(input logic [ND-1:0] rdy);
    @(negedge clk);
    #2 reset_n = 1'b0;
    soft_rst_req = 1'b0;
    domain_ready = rdy;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold;
    hold = 0;
    repeat (2) @(negedge clk);
    chk("reset rst_n_out", 32'(domain_rst_n_out), 32'h0);
    chk("reset busy", 32'(busy), 32'h1);
    chk("reset all_released", 32'(all_released), 32'h0);
    chk("reset timeout_err", 32'(timeout_err), 32'h0);
    chk("reset cur_domain", 32'(cur_domain), 32'h0);
    reset_n = 1'b1;

    // Power-on with every ready high
    wait_edge(3);  chk("pwr e3", 32'(domain_rst_n_out), 32'h0);
    wait_edge(4);  chk("pwr e4", 32'(domain_rst_n_out), 32'h1);
    wait_edge(9);  chk("pwr e9", 32'(domain_rst_n_out), 32'h3);
    wait_edge(14); chk("pwr e14", 32'(domain_rst_n_out), 32'h7);
    wait_edge(19); chk("pwr e19", 32'(domain_rst_n_out), 32'hF);
    chk("pwr e19 all", 32'(all_released), 32'h0);
    wait_edge(20); chk("pwr e20 all", 32'(all_released), 32'h1);
    chk("pwr e20 busy", 32'(busy), 32'h0);
    chk("pwr e20 terr", 32'(timeout_err), 32'h0);
    chk("pwr e20 cur", 32'(cur_domain), 32'h3);

    // One-cycle soft reset from RUN
    soft_rst_req = 1'b1;
    wait_edge(21);
    soft_rst_req = 1'b0;
    chk("soft e21 rst", 32'(domain_rst_n_out), 32'h0);
    chk("soft e21 all", 32'(all_released), 32'h0);
    chk("soft e21 cur", 32'(cur_domain), 32'h0);
    wait_edge(28); chk("soft e28", 32'(domain_rst_n_out), 32'h0);
    wait_edge(29); chk("soft e29", 32'(domain_rst_n_out), 32'h1);
    wait_edge(45); chk("soft e45 all", 32'(all_released), 32'h1);

    // Domain 1 never acknowledges
    do_reset(4'b1101);
    wait_edge(9);  chk("tmo e9", 32'(domain_rst_n_out), 32'h3);
    wait_edge(16); chk("tmo e16 terr", 32'(timeout_err), 32'h0);
    wait_edge(17); chk("tmo e17 terr", 32'(timeout_err), 32'h1);
    wait_edge(20); chk("tmo e20", 32'(domain_rst_n_out), 32'h3);
    wait_edge(21); chk("tmo e21", 32'(domain_rst_n_out), 32'h7);
    wait_edge(26); chk("tmo e26 all", 32'(all_released), 32'h0);
    wait_edge(27); chk("tmo e27 all", 32'(all_released), 32'h1);

    // Soft reset held for 20 sampled edges
    soft_rst_req = 1'b1;
    wait_edge(28); chk("hold e28 terr", 32'(timeout_err), 32'h0);
    chk("hold e28 rst", 32'(domain_rst_n_out), 32'h0);
    wait_edge(47); chk("hold e47 rst", 32'(domain_rst_n_out), 32'h0);
    soft_rst_req = 1'b0;
    wait_edge(51); chk("hold e51", 32'(domain_rst_n_out), 32'h0);
    wait_edge(52); chk("hold e52", 32'(domain_rst_n_out), 32'h1);

    // Abort while waiting on domain 1
    do_reset(4'b1101);
    wait_edge(10); chk("abort e10 rst", 32'(domain_rst_n_out), 32'h3);
    chk("abort e10 cur", 32'(cur_domain), 32'h1);
    soft_rst_req = 1'b1;
    wait_edge(11);
    soft_rst_req = 1'b0;
    chk("abort e11 rst", 32'(domain_rst_n_out), 32'h0);
    chk("abort e11 cur", 32'(cur_domain), 32'h0);
    wait_edge(18); chk("abort e18", 32'(domain_rst_n_out), 32'h0);
    wait_edge(19); chk("abort e19", 32'(domain_rst_n_out), 32'h1);

    // Asynchronous reset between edges 15 and 16
    do_reset('1);
    wait_edge(15); chk("async e15", 32'(domain_rst_n_out), 32'h7);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst_n_out", 32'(domain_rst_n_out), 32'h0);
    chk("async busy", 32'(busy), 32'h1);
    chk("async cur", 32'(cur_domain), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_edge(4);  chk("async re e4", 32'(domain_rst_n_out), 32'h1);
    wait_edge(19); chk("async re e19", 32'(domain_rst_n_out), 32'hF);
    wait_edge(20); chk("async re e20 all", 32'(all_released), 32'h1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) domain_ready = ND'($urandom | $urandom);
      if (hold > 0) begin
        hold--;
        if (hold == 0) soft_rst_req = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        soft_rst_req = 1'b1;
        hold = $urandom_range(1, 25);
      end
      if ($urandom_range(0, 799) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
